// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring DIV/DIVU unit for the HI/LO path
// Define DIV_ZERO_FAST_EN to resolve zero divisors in IDLE without the BUSY sequence.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_ext, trial;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fix_rem, fix_quo;

  assign ready = ~start | (state_q == DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_div && b[WIDTH-1]) ? -b : b;

    // Shifted remainder needs one extra bit before the trial subtract.
    rem_ext = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_ext - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      step_rem = trial[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = rem_ext[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
    fix_quo = qneg_q ? -step_quo : step_quo;
    fix_rem = rneg_q ? -step_rem : step_rem;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            hi_d    = a;
            lo_d    = '1;
            done_d  = 1'b1;
            state_d = DONE;
          end else
`endif
          begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            dvd_d   = a;
            qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = signed_div & a[WIDTH-1];
            zero_d  = (b == '0);
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          hi_d    = zero_q ? dvd_q : fix_rem;
          lo_d    = zero_q ? '1 : fix_quo;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      // The start still visible here belongs to the departing instruction.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cancel) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_STALL = 1;
`else
  localparam int ZERO_STALL = 33;
`endif

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called mid-cycle; returns mid-cycle in the cycle after DONE.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] elo,
                        input logic [31:0] ehi, input int estall, input logic keep);
    int stall;
    signed_div = sgn;
    a          = av;
    b          = bv;
    start      = 1'b1;
    #1;
    stall = 0;
    while (!ready && stall < 200) begin
      stall++;
      if (stall == 5) begin
        a          = ~av;
        b          = bv + 32'd3;
        signed_div = ~sgn;
      end
      @(posedge clk);
      #2;
    end
    check({tag, " stall"}, 32'(stall), 32'(estall));
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " lo"}, lo, elo);
    check({tag, " hi"}, hi, ehi);
    @(posedge clk);
    #2;
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    if (!keep) start = 1'b0;
  endtask

  task automatic idle_watch(input string tag, input int cycles, input logic [31:0] elo,
                            input logic [31:0] ehi);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      if (done) pulses++;
    end
    check({tag, " no_done"}, 32'(pulses), 32'd0);
    check({tag, " lo_kept"}, lo, elo);
    check({tag, " hi_kept"}, hi, ehi);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    cancel     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset ready", {31'b0, ready}, 32'd1);
    @(posedge clk);
    #2;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    do_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 1'b0);
    do_div("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33, 1'b0);
    do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0);
    do_div("divu /0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, ZERO_STALL, 1'b0);
    do_div("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, ZERO_STALL, 1'b0);
    do_div("divu max/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 1'b0);

    // Cancel at BUSY cycle 10 keeps the previous result.
    signed_div = 1'b0;
    a          = 32'd50;
    b          = 32'd5;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    cancel = 1'b1;
    start  = 1'b0;
    @(posedge clk);
    #2;
    cancel = 1'b0;
    check("cancel done", {31'b0, done}, 32'd0);
    check("cancel ready", {31'b0, ready}, 32'd1);
    idle_watch("cancel", 40, 32'h0FFF_FFFF, 32'hF);
    do_div("divu 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33, 1'b0);

    // Start coinciding with cancel in IDLE never launches.
    a      = 32'd9;
    b      = 32'd2;
    start  = 1'b1;
    cancel = 1'b1;
    @(posedge clk);
    #2;
    start  = 1'b0;
    cancel = 1'b0;
    idle_watch("start+cancel", 40, 32'd10, 32'd0);

    // Reset mid-divide clears results.
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst ready", {31'b0, ready}, 32'd1);

    do_div("b2b 9/2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 33, 1'b1);
    do_div("b2b 17/5", 1'b0, 32'd17, 32'd5, 32'd3, 32'd2, 33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
